// File: rtl/persp_pkg.sv
// Shared types, constants and clamping helper for the perspective/viewport stage.
package persp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_MUL,
        ST_VIEW,
        ST_OUT
    } state_e;

    function automatic int one_f(input int fracbits);
        return 1 << fracbits;
    endfunction

    function automatic int half_f(input int dim);
        return dim / 2;
    endfunction

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/recip_div.sv
// Iterative restoring divider producing floor(2^(2*FRACBITS) / divisor), one quotient
// bit per cycle, with the result clamped to the positive signed DATAWIDTH range.
module recip_div
    import persp_pkg::*;
#(
    parameter int DATAWIDTH = 18,
    parameter int FRACBITS  = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [DATAWIDTH-1:0] divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATAWIDTH-1:0] recip_o
);

    localparam int QW = 2 * FRACBITS + 1;
    localparam int CW = $clog2(QW + 1);
    localparam logic [QW-1:0] QMAX = QW'((1 << (DATAWIDTH - 1)) - 1);

    logic [QW-1:0]        num_q, num_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic [DATAWIDTH-1:0] rem_q, rem_d;
    logic [DATAWIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH:0]   trial;

    always_comb begin
        num_d = num_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        trial = {rem_q, num_q[QW-1]};
        if (start_i) begin
            num_d = QW'(1) << (QW - 1);
            quo_d = '0;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = CW'(QW);
        end else if (cnt_q != '0) begin
            num_d = num_q << 1;
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = DATAWIDTH'(trial - {1'b0, dvs_q});
                quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
                rem_d = trial[DATAWIDTH-1:0];
                quo_d = {quo_q[QW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            num_q <= num_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    // done marks the cycle whose closing edge commits the final quotient bit.
    assign busy_o  = (cnt_q != '0);
    assign done_o  = (cnt_q == CW'(1));
    assign recip_o = (quo_q > QMAX) ? QMAX[DATAWIDTH-1:0] : quo_q[DATAWIDTH-1:0];

endmodule

// File: rtl/persp_viewport.sv
// Clip-space vertex to screen-space pixel coordinates and NDC depth.
//   state   | meaning
//   IDLE    | ready for a vertex; w <= 0 goes straight to OUT as clipped
//   DIV     | reciprocal of w being computed
//   MUL     | ndc = clip * recip
//   VIEW    | viewport mapping into pixel coordinates
//   OUT     | result presented until downstream accepts
module persp_viewport
    import persp_pkg::*;
#(
    parameter int DATAWIDTH = 18,
    parameter int FRACBITS  = 12,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [DATAWIDTH-1:0] clip [4],
    input  logic                        i_dv,
    output logic                        o_ready,
    output logic                        o_drop,
    output logic signed [DATAWIDTH-1:0] o_sx,
    output logic signed [DATAWIDTH-1:0] o_sy,
    output logic signed [DATAWIDTH-1:0] o_depth,
    output logic                        o_clipped,
    output logic                        o_dv,
    input  logic                        i_ready
);

    localparam logic signed [63:0] ONE_W  = 64'(one_f(FRACBITS));
    localparam logic signed [63:0] HALF_W = 64'(half_f(SCREEN_W));
    localparam logic signed [63:0] HALF_H = 64'(half_f(SCREEN_H));

    state_e state_q, state_d;

    logic signed [DATAWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [DATAWIDTH-1:0] ndc_x_q, ndc_x_d, ndc_y_q, ndc_y_d, ndc_z_q, ndc_z_d;
    logic signed [DATAWIDTH-1:0] sx_q, sx_d, sy_q, sy_d, depth_q, depth_d;
    logic                        clipped_q, clipped_d;
    logic                        drop_q, drop_d;

    logic                          div_start, div_busy, div_done;
    logic [DATAWIDTH-1:0]          recip;
    logic signed [DATAWIDTH-1:0]   recip_s;
    logic signed [2*DATAWIDTH-1:0] prod_x, prod_y, prod_z;
    logic signed [63:0]            view_x, view_y;

    recip_div #(
        .DATAWIDTH(DATAWIDTH),
        .FRACBITS (FRACBITS)
    ) u_recip_div (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (div_start),
        .divisor_i(clip[3]),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .recip_o  (recip)
    );

    assign recip_s = $signed(recip);
    assign prod_x  = x_q * recip_s;
    assign prod_y  = y_q * recip_s;
    assign prod_z  = z_q * recip_s;
    assign view_x  = ((64'(ndc_x_q) + ONE_W) * HALF_W) >>> FRACBITS;
    assign view_y  = ((ONE_W - 64'(ndc_y_q)) * HALF_H) >>> FRACBITS;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        ndc_x_d   = ndc_x_q;
        ndc_y_d   = ndc_y_q;
        ndc_z_d   = ndc_z_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        depth_d   = depth_q;
        clipped_d = clipped_q;
        div_start = 1'b0;
        drop_d    = i_dv && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (i_dv) begin
                    x_d = clip[0];
                    y_d = clip[1];
                    z_d = clip[2];
                    if (clip[3][DATAWIDTH-1] || (clip[3] == '0)) begin
                        sx_d      = '0;
                        sy_d      = '0;
                        depth_d   = '0;
                        clipped_d = 1'b1;
                        state_d   = ST_OUT;
                    end else begin
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_MUL;
                end else if (!div_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                ndc_x_d = DATAWIDTH'(sat_s(64'(prod_x >>> FRACBITS), DATAWIDTH));
                ndc_y_d = DATAWIDTH'(sat_s(64'(prod_y >>> FRACBITS), DATAWIDTH));
                ndc_z_d = DATAWIDTH'(sat_s(64'(prod_z >>> FRACBITS), DATAWIDTH));
                state_d = ST_VIEW;
            end
            ST_VIEW: begin
                sx_d      = DATAWIDTH'(sat_s(view_x, DATAWIDTH));
                sy_d      = DATAWIDTH'(sat_s(view_y, DATAWIDTH));
                depth_d   = ndc_z_q;
                clipped_d = 1'b0;
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            ndc_x_q   <= '0;
            ndc_y_q   <= '0;
            ndc_z_q   <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            depth_q   <= '0;
            clipped_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            ndc_x_q   <= ndc_x_d;
            ndc_y_q   <= ndc_y_d;
            ndc_z_q   <= ndc_z_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            depth_q   <= depth_d;
            clipped_q <= clipped_d;
            drop_q    <= drop_d;
        end
    end

    assign o_ready   = (state_q == ST_IDLE);
    assign o_dv      = (state_q == ST_OUT);
    assign o_drop    = drop_q;
    assign o_sx      = sx_q;
    assign o_sy      = sy_q;
    assign o_depth   = depth_q;
    assign o_clipped = clipped_q;

endmodule
